// File: rtl/ganmind_pkg.sv
// Constants and types shared by the ganmind pixel loader and its frame source arbiter.
package ganmind_pkg;

   localparam int unsigned GM_PIXEL_COUNT = 784;
   localparam int unsigned GM_NUM_SRC     = 4;
   localparam int unsigned GM_SRC_ID_W    = 2;
   localparam int unsigned GM_BEAT_W      = 16;
   localparam int unsigned GM_TAG_DEPTH   = 4;
   localparam int unsigned GM_TAG_ADDR_W  = 2;

   typedef enum logic {
      ARB_IDLE,
      ARB_STREAM
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester strictly after the last grant, in index order, wrapping.
module rr_arbiter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] grant,
   output logic         any
);

   int unsigned base;
   logic [W-1:0] sel;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      sel   = '0;
      base  = 32'(last);
      for (int unsigned i = 1; i <= N; i++) begin
         sel = W'((base + i) % N);
         if (!any && req[sel]) begin
            grant = sel;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_source_arbiter.sv
// Locks one serial pixel source onto the shared loader for a whole frame and
// records each completed frame's source in a small tag queue until consumed.
module frame_source_arbiter
   import ganmind_pkg::*;
#(
   parameter int unsigned NUM_SRC     = GM_NUM_SRC,
   parameter int unsigned SRC_ID_W    = GM_SRC_ID_W,
   parameter int unsigned PIXEL_COUNT = GM_PIXEL_COUNT,
   parameter int unsigned TAG_DEPTH   = GM_TAG_DEPTH,
   parameter int unsigned TAG_ADDR_W  = GM_TAG_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  src_bit,
   input  logic [NUM_SRC-1:0]  src_valid,
   output logic [NUM_SRC-1:0]  src_ready,
   output logic                ldr_bit,
   output logic                ldr_valid,
   input  logic                ldr_ready,
   input  logic                frame_consume,
   output logic [SRC_ID_W-1:0] tag_id,
   output logic                tag_valid,
   output logic                busy,
   output logic [SRC_ID_W-1:0] grant_id
);

   localparam logic [GM_BEAT_W-1:0] LAST_BEAT = GM_BEAT_W'(PIXEL_COUNT - 1);
   localparam logic [TAG_ADDR_W:0]  TAG_FULL  = (TAG_ADDR_W + 1)'(TAG_DEPTH);

   arb_state_t            state;
   logic [GM_BEAT_W-1:0]  beat_cnt;
   logic [SRC_ID_W-1:0]   rr_last;
   logic [SRC_ID_W-1:0]   rr_grant;
   logic                  rr_any;
   logic                  can_grant;
   logic                  beat_ok;
   logic                  last_beat;
   logic                  push;
   logic                  pop;

   logic [SRC_ID_W-1:0]   tag_mem [TAG_DEPTH];
   logic [TAG_ADDR_W-1:0] wr_ptr;
   logic [TAG_ADDR_W-1:0] rd_ptr;
   logic [TAG_ADDR_W:0]   tag_cnt;

   rr_arbiter #(
      .N (NUM_SRC),
      .W (SRC_ID_W)
   ) u_rr (
      .req   (src_valid),
      .last  (rr_last),
      .grant (rr_grant),
      .any   (rr_any)
   );

   // Loader-side handshake is a straight combinational mux of the granted source.
   always_comb begin
      busy      = (state == ARB_STREAM);
      ldr_valid = busy & src_valid[grant_id];
      ldr_bit   = busy & src_bit[grant_id];
      src_ready = '0;
      if (busy) begin
         src_ready[grant_id] = ldr_ready;
      end
      beat_ok   = ldr_valid & ldr_ready;
      last_beat = beat_ok && (beat_cnt == LAST_BEAT);
      push      = last_beat;
      tag_valid = (tag_cnt != '0);
      tag_id    = tag_mem[rd_ptr];
      pop       = frame_consume & tag_valid;
      can_grant = rr_any && (tag_cnt < TAG_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         beat_cnt <= '0;
         rr_last  <= SRC_ID_W'(NUM_SRC - 1);
         grant_id <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (can_grant) begin
                  grant_id <= rr_grant;
                  rr_last  <= rr_grant;
                  state    <= ARB_STREAM;
               end
            end
            ARB_STREAM: begin
               if (beat_ok) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     state    <= ARB_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Tag storage needs no reset; validity is carried entirely by tag_cnt.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= grant_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Directed bench for frame_source_arbiter with an expected-tag scoreboard queue.
module tb_frame_source_arbiter;

   localparam int PIX = 784;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src_bit;
   logic [3:0] src_valid;
   logic [3:0] src_ready;
   logic       ldr_bit;
   logic       ldr_valid;
   logic       ldr_ready;
   logic       frame_consume;
   logic [1:0] tag_id;
   logic       tag_valid;
   logic       busy;
   logic [1:0] grant_id;

   int nerr = 0;
   int nchk = 0;
   int exp_q[$];

   frame_source_arbiter #(
      .NUM_SRC     (4),
      .SRC_ID_W    (2),
      .PIXEL_COUNT (PIX),
      .TAG_DEPTH   (4),
      .TAG_ADDR_W  (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .src_bit       (src_bit),
      .src_valid     (src_valid),
      .src_ready     (src_ready),
      .ldr_bit       (ldr_bit),
      .ldr_valid     (ldr_valid),
      .ldr_ready     (ldr_ready),
      .frame_consume (frame_consume),
      .tag_id        (tag_id),
      .tag_valid     (tag_valid),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      src_valid     = '0;
      src_bit       = '1;
      ldr_ready     = 1'b1;
      frame_consume = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic consume_one();
      int head;
      head = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      frame_consume = 1'b1;
      #2;
      chk("consume_tag_valid", int'(tag_valid), 1);
      chk("consume_tag_id", int'(tag_id), head);
      tick();
      frame_consume = 1'b0;
   endtask

   // Waits for the grant, then streams one frame counting modelled handshakes.
   task automatic run_frame(input int src, input bit rnd, input int late_src, input int late_beat,
                            input bit consume_last, input int abort_beat, input int exp_wait);
      int waited = 0;
      int beats  = 0;
      int cyc    = 0;
      int head;
      bit hs;
      while (!busy && waited < 50) begin
         tick();
         waited++;
      end
      chk("grant_busy", int'(busy), 1);
      chk("grant_id", int'(grant_id), src);
      if (exp_wait >= 0) chk("grant_latency", waited, exp_wait);
      while (busy && cyc < 10000) begin
         if (abort_beat >= 0 && beats == abort_beat) break;
         ldr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         src_bit   = 4'($urandom);
         if (rnd) src_valid[src] = 1'($urandom_range(0, 1));
         if (late_src >= 0 && beats == late_beat) src_valid[late_src] = 1'b1;
         #2;
         hs = src_valid[src] && ldr_ready;
         chk("grant_hold", int'(grant_id), src);
         chk("ldr_valid", int'(ldr_valid), int'(src_valid[src]));
         chk("ldr_bit", int'(ldr_bit), int'(src_bit[src]));
         chk("src_ready", int'(src_ready), ldr_ready ? (1 << src) : 0);
         if (consume_last && hs && beats == PIX - 1) begin
            head = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            frame_consume = 1'b1;
            chk("final_consume_tag_id", int'(tag_id), head);
         end
         if (hs) beats++;
         tick();
         frame_consume = 1'b0;
         cyc++;
      end
      if (abort_beat < 0) begin
         chk("frame_end_busy", int'(busy), 0);
         chk("frame_beats", beats, PIX);
      end
      if (rnd) src_valid[src] = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_tag_valid", int'(tag_valid), 0);
      chk("rst_src_ready", int'(src_ready), 0);
      chk("rst_ldr_valid", int'(ldr_valid), 0);
      chk("rst_ldr_bit", int'(ldr_bit), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      tick();

      // Single source 2, one-cycle grant latency, full frame, tag recorded
      src_valid = 4'b0100;
      exp_q.push_back(2);
      run_frame(2, 1'b0, -1, -1, 1'b0, -1, 1);
      src_valid = '0;
      #2;
      chk("t1_tag_valid", int'(tag_valid), 1);
      chk("t1_tag_id", int'(tag_id), exp_q[0]);
      tick();
      consume_one();
      #2;
      chk("t1_empty", int'(tag_valid), 0);

      // All sources valid: 0,1,2,3 then stall on full queue, consume unblocks source 0
      do_reset();
      src_valid = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         exp_q.push_back(s);
         run_frame(s, 1'b0, -1, -1, 1'b0, -1, -1);
      end
      repeat (10) tick();
      chk("full_stall_busy", int'(busy), 0);
      consume_one();
      exp_q.push_back(0);
      run_frame(0, 1'b0, -1, -1, 1'b0, -1, -1);
      src_valid = '0;
      repeat (4) consume_one();
      #2;
      chk("t2_drained", int'(tag_valid), 0);

      // Source 0 arrives mid-frame of source 1 and waits its turn
      do_reset();
      src_valid = 4'b0010;
      exp_q.push_back(1);
      run_frame(1, 1'b0, 0, 100, 1'b0, -1, 1);
      exp_q.push_back(0);
      run_frame(0, 1'b0, -1, -1, 1'b0, -1, -1);
      src_valid = '0;
      repeat (2) consume_one();

      // Random ldr_ready and src_valid on source 3
      do_reset();
      src_valid = 4'b1000;
      exp_q.push_back(3);
      run_frame(3, 1'b1, -1, -1, 1'b0, -1, 1);

      // Consume on the final beat of the next frame with one tag queued
      src_valid = 4'b0001;
      exp_q.push_back(0);
      run_frame(0, 1'b0, -1, -1, 1'b1, -1, -1);
      src_valid = '0;
      #2;
      chk("t5_tag_valid", int'(tag_valid), 1);
      chk("t5_tag_id", int'(tag_id), exp_q[0]);
      tick();
      consume_one();
      #2;
      chk("t5_count_one", int'(tag_valid), 0);
      tick();

      // Reset at beat 400 abandons the frame; the following frame is full length
      src_valid = 4'b0100;
      run_frame(2, 1'b0, -1, -1, 1'b0, 400, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      chk("abort_busy", int'(busy), 0);
      chk("abort_tag_valid", int'(tag_valid), 0);
      chk("abort_src_ready", int'(src_ready), 0);
      chk("abort_ldr_valid", int'(ldr_valid), 0);
      exp_q.delete();
      exp_q.push_back(2);
      run_frame(2, 1'b0, -1, -1, 1'b0, -1, -1);
      src_valid = '0;
      consume_one();
      #2;
      chk("t6_empty", int'(tag_valid), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
